_shift_out32: RTL and testbench

Parallel-to-serial transmitter for 32-bit register words. It accepts a word on a valid/ready load port and shifts it out one bit per accepted serial beat, with first/last framing. It sits downstream of a 32-bit data register and drives a serial link or a matching serial-to-parallel receiver. Back-to-back words stream with no idle gap.

---
 rtl/_shift_out32_pkg.sv | 11 +
 rtl/_shift_out32_bit_counter.sv | 38 +++
 rtl/_shift_out32.sv | 95 +++++++++
 tb/tb__shift_out32.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/_shift_out32_pkg.sv
// Shared types and defaults for the 32-bit parallel-to-serial transmitter.
package _shift_out32_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

endpackage

// File: rtl/_shift_out32_bit_counter.sv
// Beat counter with clear, increment enable and last-position flag; shared with the receiver.
module _shift_out32_bit_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     inc,
  output logic [$clog2(WIDTH)-1:0] cnt,
  output logic                     is_last
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Clear has priority so a last beat never wraps the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign is_last = (cnt_q == CntW'(WIDTH - 1));

endmodule

// File: rtl/_shift_out32.sv
// Parallel-to-serial transmitter: loads a word on a valid/ready port and shifts it out
// one bit per accepted beat with first/last framing; back-to-back words stream gap-free.
module _shift_out32
  import _shift_out32_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_first,
  output logic             sout_last,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt;
  logic             is_last;
  logic             beat;
  logic             load_acc;
  logic             cnt_clr;

  _shift_out32_bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr),
    .inc    (beat),
    .cnt    (cnt),
    .is_last(is_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (load_acc) state_d = StShift;
      end
      StShift: begin
        // A load on the last beat keeps the link busy with no idle cycle.
        if (beat && is_last && !load_acc) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sout_valid = (state_q == StShift);
    load_ready = !reset && ((state_q == StIdle) || (is_last && sout_ready));
    beat       = sout_valid && sout_ready;
    load_acc   = load_valid && load_ready;
    cnt_clr    = load_acc || (beat && is_last);
    sout_first = sout_valid && (cnt == '0);
    sout_last  = sout_valid && is_last;
    busy       = sout_valid;
  end

  always_comb begin
    shreg_d = shreg_q;
    if (load_acc) begin
      shreg_d = load_data;
    end else if (beat) begin
      shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign sout = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

endmodule

// File: tb/tb__shift_out32.sv
// Bench for _shift_out32: MSB-first and LSB-first instances share stimulus and are compared
// every cycle against queue-based models of the expected serial bit stream.
module tb__shift_out32;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         sout_ready;

  logic load_ready_m, sout_m, sout_valid_m, sout_first_m, sout_last_m, busy_m;
  logic load_ready_l, sout_l, sout_valid_l, sout_first_l, sout_last_l, busy_l;

  always #5 clk = ~clk;

  _shift_out32 #(
    .WIDTH    (W),
    .MSB_FIRST(1'b1)
  ) dut_m (
    .clk       (clk),
    .reset     (reset),
    .load_valid(load_valid),
    .load_ready(load_ready_m),
    .load_data (load_data),
    .sout      (sout_m),
    .sout_valid(sout_valid_m),
    .sout_ready(sout_ready),
    .sout_first(sout_first_m),
    .sout_last (sout_last_m),
    .busy      (busy_m)
  );

  _shift_out32 #(
    .WIDTH    (W),
    .MSB_FIRST(1'b0)
  ) dut_l (
    .clk       (clk),
    .reset     (reset),
    .load_valid(load_valid),
    .load_ready(load_ready_l),
    .load_data (load_data),
    .sout      (sout_l),
    .sout_valid(sout_valid_l),
    .sout_ready(sout_ready),
    .sout_first(sout_first_l),
    .sout_last (sout_last_l),
    .busy      (busy_l)
  );

  int checks = 0;
  int errors = 0;

  // Expected bits still to be sent, head = bit currently on sout.
  bit q_m[$];
  bit q_l[$];

  logic [W-1:0] rx_m, rx_l;
  int           beats, cyc_valid, rdy_pulses, n_acc;
  logic         last_acc;
  logic         stall_prev;
  logic         sout_prev_m, sout_prev_l;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_stats();
    rx_m       = '0;
    rx_l       = '0;
    beats      = 0;
    cyc_valid  = 0;
    rdy_pulses = 0;
    n_acc      = 0;
  endtask

  // Called just after a falling edge with inputs already driven; returns after the next one.
  task automatic cycle();
    logic exp_v, exp_rdy, exp_first, exp_last, beat;
    logic [W-1:0] word;
    if (reset) begin
      q_m.delete();
      q_l.delete();
    end
    #1;
    exp_v     = (q_m.size() != 0);
    exp_rdy   = !reset && (q_m.size() == 0 || (q_m.size() == 1 && sout_ready));
    exp_first = exp_v && (q_m.size() == W);
    exp_last  = exp_v && (q_m.size() == 1);
    check("ready_m", load_ready_m, exp_rdy);
    check("ready_l", load_ready_l, exp_rdy);
    check("valid_m", sout_valid_m, exp_v);
    check("valid_l", sout_valid_l, exp_v);
    check("busy_m", busy_m, exp_v);
    check("busy_l", busy_l, exp_v);
    check("first_m", sout_first_m, exp_first);
    check("first_l", sout_first_l, exp_first);
    check("last_m", sout_last_m, exp_last);
    check("last_l", sout_last_l, exp_last);
    check("sout_m", sout_m, exp_v ? q_m[0] : 1'b0);
    check("sout_l", sout_l, exp_v ? q_l[0] : 1'b0);
    if (stall_prev && exp_v) begin
      check("hold_m", sout_m, sout_prev_m);
      check("hold_l", sout_l, sout_prev_l);
    end
    last_acc = load_valid && exp_rdy;
    beat     = exp_v && sout_ready && !reset;
    if (beat) begin
      rx_m = {rx_m[W-2:0], sout_m};
      rx_l = {sout_l, rx_l[W-1:1]};
      beats++;
    end
    if (exp_v) cyc_valid++;
    if (exp_v && exp_rdy) rdy_pulses++;
    if (last_acc) n_acc++;
    stall_prev  = exp_v && !sout_ready && !reset;
    sout_prev_m = sout_m;
    sout_prev_l = sout_l;
    word        = load_data;
    @(posedge clk);
    if (!reset) begin
      if (beat) begin
        void'(q_m.pop_front());
        void'(q_l.pop_front());
      end
      if (last_acc) begin
        for (int i = 0; i < W; i++) begin
          q_m.push_back(word[W-1-i]);
          q_l.push_back(word[i]);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic load_word(input logic [W-1:0] w);
    load_data  = w;
    load_valid = 1'b1;
    cycle();
    load_valid = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    sout_ready = 1'b1;
    stall_prev = 1'b0;
    clear_stats();
    repeat (2) @(negedge clk);
    cycle();
    reset = 1'b0;

    // Single frame: MSB-first and LSB-first ordering, framing and length.
    clear_stats();
    load_word(32'h2019_0923);
    repeat (8) cycle();
    check("t1_msb_first8", rx_m[7:0], 32'h20);
    check("t1_lsb_first8", rx_l[31:24], 32'h23);
    repeat (24) cycle();
    check("t1_word_m", rx_m, 32'h2019_0923);
    check("t1_word_l", rx_l, 32'h2019_0923);
    check("t1_cycles", cyc_valid, 32);
    cycle();

    // Back-to-back words with load_valid held high.
    clear_stats();
    load_data  = 32'h1234_5678;
    load_valid = 1'b1;
    cycle();
    load_data = 32'h8765_4321;
    for (int i = 0; i < 64; i++) begin
      if (n_acc >= 2) load_valid = 1'b0;
      cycle();
    end
    load_valid = 1'b0;
    check("t3_valid_cycles", cyc_valid, 64);
    check("t3_beats", beats, 64);
    check("t3_ready_pulses", rdy_pulses, 2);
    check("t3_accepts", n_acc, 2);
    check("t3_word2_m", rx_m, 32'h8765_4321);
    check("t3_word2_l", rx_l, 32'h8765_4321);
    cycle();

    // Stall every other cycle.
    clear_stats();
    load_word(32'hffff_0000);
    for (int i = 0; i < 63; i++) begin
      sout_ready = (i % 2 == 0);
      cycle();
    end
    sout_ready = 1'b1;
    check("t4_cycles", cyc_valid, 63);
    check("t4_beats", beats, 32);
    check("t4_word_m", rx_m, 32'hffff_0000);
    check("t4_word_l", rx_l, 32'hffff_0000);
    cycle();

    // Reset mid-frame, then a fresh frame.
    clear_stats();
    load_word(32'h0000_ffff);
    repeat (10) cycle();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    clear_stats();
    load_word(32'hffff_ffff);
    repeat (32) cycle();
    check("t5_word_m", rx_m, 32'hffff_ffff);
    check("t5_word_l", rx_l, 32'hffff_ffff);
    check("t5_beats", beats, 32);
    cycle();

    // Load pulse mid-frame must be ignored.
    clear_stats();
    load_word(32'ha5c3_3c5a);
    repeat (5) cycle();
    load_data  = 32'h1111_2222;
    load_valid = 1'b1;
    cycle();
    load_valid = 1'b0;
    repeat (26) cycle();
    check("t6_accepts", n_acc, 1);
    check("t6_word_m", rx_m, 32'ha5c3_3c5a);
    check("t6_word_l", rx_l, 32'ha5c3_3c5a);
    cycle();

    // Randomised traffic; data held until accepted.
    last_acc = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 299) == 0);
      sout_ready = ($urandom_range(0, 3) != 0);
      if (!load_valid || last_acc) begin
        load_valid = $urandom_range(0, 1) == 1;
        load_data  = $urandom;
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
